amm_write_block: RTL and testbench

Avalon-MM burst write generator for the memory checker; the write-side counterpart of the read-data comparator. Accepts one test packet at a time (address, word count, edge byte masks, data pattern seed and mode) and emits one write burst whose data and byteenables match exactly what the comparator later expects on read-back. It sits between the test-sequencer packet source and the Avalon-MM master port.

---
 rtl/amm_write_block.sv | 158 +++++++++++++++
 tb/tb_amm_write_block.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amm_write_block.sv
// Avalon-MM burst write generator: turns one stored test packet into one write burst whose
// data and byteenables match what the read-back comparator expects.
module amm_write_block #(
  parameter int unsigned AMM_DATA_W  = 64,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned AMM_BURST_W = 11,
  parameter string       ADDR_TYPE   = "BYTE",
  localparam int unsigned DATA_B_W   = AMM_DATA_W / 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pkt_valid_i,
  output logic                   pkt_ready_o,
  input  logic [ADDR_W-1:0]      pkt_word_addr_i,
  input  logic [15:0]            pkt_word_count_i,
  input  logic [DATA_B_W-1:0]    pkt_start_mask_i,
  input  logic [DATA_B_W-1:0]    pkt_middle_mask_i,
  input  logic [DATA_B_W-1:0]    pkt_end_mask_i,
  input  logic [7:0]             pkt_data_ptrn_i,
  input  logic                   pkt_data_ptrn_mode_i,
  output logic [ADDR_W-1:0]      address_o,
  output logic                   write_o,
  output logic [AMM_DATA_W-1:0]  writedata_o,
  output logic [DATA_B_W-1:0]    byteenable_o,
  output logic [AMM_BURST_W-1:0] burstcount_o,
  input  logic                   waitrequest_i,
  output logic                   busy_o
);

  localparam bit WordAddr = (ADDR_TYPE == "WORD");
  localparam logic [ADDR_W-1:0] ByteAddrMask = ~(ADDR_W'(DATA_B_W) - ADDR_W'(1));

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  // One-entry packet storage
  logic                st_valid_q, st_valid_d;
  logic [ADDR_W-1:0]   st_addr_q;
  logic [15:0]         st_count_q;
  logic [DATA_B_W-1:0] st_start_mask_q, st_middle_mask_q, st_end_mask_q;
  logic [7:0]          st_ptrn_q;
  logic                st_mode_q;

  // Burst state
  state_e                 state_q, state_d;
  logic [15:0]            beats_q, beats_d;
  logic [DATA_B_W-1:0]    end_mask_q, end_mask_d;
  logic                   mode_q, mode_d;
  logic [7:0]             ptrn_q, ptrn_d;
  logic                   write_q, write_d;
  logic [ADDR_W-1:0]      address_q, address_d;
  logic [AMM_BURST_W-1:0] burstcount_q, burstcount_d;
  logic [DATA_B_W-1:0]    byteenable_q, byteenable_d;
  logic                   busy_q, busy_d;

  logic pkt_hs, accept, last_accept, load_stb;

  assign pkt_ready_o = !st_valid_q;
  assign pkt_hs      = pkt_valid_i && pkt_ready_o;
  assign st_valid_d  = pkt_hs || (st_valid_q && !load_stb);
  assign busy_d      = st_valid_q || (state_q == StBurst);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      st_valid_q <= 1'b0;
    end else begin
      st_valid_q <= st_valid_d;
    end
  end

  // Payload needs no reset: it is only consumed while st_valid_q is set.
  always_ff @(posedge clk_i) begin
    if (pkt_hs) begin
      st_addr_q        <= pkt_word_addr_i;
      st_count_q       <= pkt_word_count_i;
      st_start_mask_q  <= pkt_start_mask_i;
      st_middle_mask_q <= pkt_middle_mask_i;
      st_end_mask_q    <= pkt_end_mask_i;
      st_ptrn_q        <= pkt_data_ptrn_i;
      st_mode_q        <= pkt_data_ptrn_mode_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    beats_d      = beats_q;
    end_mask_d   = end_mask_q;
    mode_d       = mode_q;
    ptrn_d       = ptrn_q;
    write_d      = write_q;
    address_d    = address_q;
    burstcount_d = burstcount_q;
    byteenable_d = byteenable_q;

    accept      = write_q && !waitrequest_i;
    last_accept = accept && (beats_q == 16'd1);
    load_stb    = st_valid_q && ((state_q == StIdle) || last_accept);

    if (accept) begin
      beats_d      = beats_q - 16'd1;
      byteenable_d = (beats_q == 16'd2) ? end_mask_q : '1;
      if (mode_q) begin
        ptrn_d = {ptrn_q[6:0], ptrn_q[6] ^ ptrn_q[1] ^ ptrn_q[0]};
      end
    end

    if (last_accept) begin
      state_d = StIdle;
      write_d = 1'b0;
    end

    // A zero-count packet is consumed by load_stb without starting a burst.
    if (load_stb && (st_count_q != 16'd0)) begin
      state_d      = StBurst;
      write_d      = 1'b1;
      beats_d      = st_count_q;
      burstcount_d = st_count_q[AMM_BURST_W-1:0];
      address_d    = WordAddr ? st_addr_q : (st_addr_q & ByteAddrMask);
      end_mask_d   = st_end_mask_q;
      mode_d       = st_mode_q;
      ptrn_d       = st_ptrn_q;
      byteenable_d = (st_count_q == 16'd1) ? st_middle_mask_q : st_start_mask_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= StIdle;
      beats_q      <= '0;
      end_mask_q   <= '0;
      mode_q       <= 1'b0;
      ptrn_q       <= '0;
      write_q      <= 1'b0;
      address_q    <= '0;
      burstcount_q <= '0;
      byteenable_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beats_q      <= beats_d;
      end_mask_q   <= end_mask_d;
      mode_q       <= mode_d;
      ptrn_q       <= ptrn_d;
      write_q      <= write_d;
      address_q    <= address_d;
      burstcount_q <= burstcount_d;
      byteenable_q <= byteenable_d;
      busy_q       <= busy_d;
    end
  end

  assign write_o      = write_q;
  assign address_o    = address_q;
  assign burstcount_o = burstcount_q;
  assign byteenable_o = byteenable_q;
  assign writedata_o  = {DATA_B_W{ptrn_q}};
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_amm_write_block.sv
// Bench for amm_write_block: expected beats are generated per packet from the write rules
// and consumed as beats are accepted; directed cases pin timing and literal values.
module tb_amm_write_block;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 32;
  localparam int unsigned BW = 11;
  localparam int unsigned BB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          pkt_valid;
  logic [AW-1:0] pkt_addr;
  logic [15:0]   pkt_count;
  logic [BB-1:0] smask, mmask, emask;
  logic [7:0]    seed;
  logic          mode;
  logic          waitreq;

  logic          ready_b, write_b, busy_b, ready_w, write_w, busy_w;
  logic [AW-1:0] addr_b, addr_w;
  logic [DW-1:0] data_b, data_w;
  logic [BB-1:0] be_b, be_w;
  logic [BW-1:0] bc_b, bc_w;

  amm_write_block #(.AMM_DATA_W(DW), .ADDR_W(AW), .AMM_BURST_W(BW), .ADDR_TYPE("BYTE")) u_dut_b (
    .clk_i(clk), .rst_i(rst_i), .pkt_valid_i(pkt_valid), .pkt_ready_o(ready_b),
    .pkt_word_addr_i(pkt_addr), .pkt_word_count_i(pkt_count), .pkt_start_mask_i(smask),
    .pkt_middle_mask_i(mmask), .pkt_end_mask_i(emask), .pkt_data_ptrn_i(seed),
    .pkt_data_ptrn_mode_i(mode), .address_o(addr_b), .write_o(write_b), .writedata_o(data_b),
    .byteenable_o(be_b), .burstcount_o(bc_b), .waitrequest_i(waitreq), .busy_o(busy_b)
  );

  amm_write_block #(.AMM_DATA_W(DW), .ADDR_W(AW), .AMM_BURST_W(BW), .ADDR_TYPE("WORD")) u_dut_w (
    .clk_i(clk), .rst_i(rst_i), .pkt_valid_i(pkt_valid), .pkt_ready_o(ready_w),
    .pkt_word_addr_i(pkt_addr), .pkt_word_count_i(pkt_count), .pkt_start_mask_i(smask),
    .pkt_middle_mask_i(mmask), .pkt_end_mask_i(emask), .pkt_data_ptrn_i(seed),
    .pkt_data_ptrn_mode_i(mode), .address_o(addr_w), .write_o(write_w), .writedata_o(data_w),
    .byteenable_o(be_w), .burstcount_o(bc_w), .waitrequest_i(waitreq), .busy_o(busy_w)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr_b;
    logic [AW-1:0] addr_w;
    logic [BW-1:0] bc;
    logic [BB-1:0] be;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    rand_wait = 1'b0;
  bit    prev_stall = 1'b0;
  logic          p_write;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;
  logic [BB-1:0] p_be;
  logic [BW-1:0] p_bc;
  logic [7:0]    lit_be [8];
  logic [7:0]    lit_d  [8];
  logic          lit_w  [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected beats of one packet, straight from the write rules.
  task automatic push_pkt();
    logic [7:0] p;
    beat_t e;
    int n;
    p = seed;
    n = int'(pkt_count);
    for (int i = 0; i < n; i++) begin
      e.addr_b = (pkt_addr / BB) * BB;
      e.addr_w = pkt_addr;
      e.bc     = pkt_count[BW-1:0];
      if (n == 1)          e.be = mmask;
      else if (i == 0)     e.be = smask;
      else if (i == n - 1) e.be = emask;
      else                 e.be = '1;
      e.data = {BB{p}};
      exp_q.push_back(e);
      if (mode) p = {p[6:0], p[6] ^ p[1] ^ p[0]};
    end
  endtask

  // Runs once per cycle, after this cycle's inputs are final and before the next edge.
  task automatic sb_compare();
    beat_t e;
    if (!rst_i) begin
      exp_q.delete();
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      check("stall_write", write_b, p_write);
      check("stall_addr", addr_b, p_addr);
      check("stall_data", data_b, p_data);
      check("stall_be", be_b, p_be);
      check("stall_bc", bc_b, p_bc);
    end
    if (write_b && !waitreq) begin
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat_addr", addr_b, e.addr_b);
        check("beat_bc", bc_b, e.bc);
        check("beat_be", be_b, e.be);
        check("beat_data", data_b, e.data);
        check("wbeat_write", write_w, 1);
        check("wbeat_addr", addr_w, e.addr_w);
        check("wbeat_bc", bc_w, e.bc);
        check("wbeat_be", be_w, e.be);
        check("wbeat_data", data_w, e.data);
      end
    end else begin
      check("wbeat_unexpected", write_w && !waitreq, 0);
    end
    prev_stall = write_b && waitreq;
    p_write = write_b;
    p_addr  = addr_b;
    p_data  = data_b;
    p_be    = be_b;
    p_bc    = bc_b;
  endtask

  task automatic tick();
    if (rand_wait) waitreq = ($urandom_range(0, 3) == 0);
    sb_compare();
    @(negedge clk);
  endtask

  // Returns one cycle after the handshake cycle.
  task automatic send_pkt(input logic [AW-1:0] a, input logic [15:0] n, input logic [BB-1:0] sm,
                          input logic [BB-1:0] mm, input logic [BB-1:0] em, input logic [7:0] s,
                          input logic m);
    int k;
    pkt_addr = a; pkt_count = n; smask = sm; mmask = mm; emask = em; seed = s; mode = m;
    pkt_valid = 1'b1;
    for (k = 0; k < 6000; k++) begin
      if (ready_b) begin
        push_pkt();
        tick();
        pkt_valid = 1'b0;
        break;
      end
      tick();
    end
    if (k == 6000) begin
      check("send_timeout", 1, 0);
      pkt_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy_b || busy_w) && n < 6000) begin
      tick();
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle"}, busy_b, 0);
  endtask

  initial begin
    rst_i = 1'b0; pkt_valid = 1'b0; pkt_addr = '0; pkt_count = '0;
    smask = '0; mmask = '0; emask = '0; seed = '0; mode = 1'b0; waitreq = 1'b0;
    lit_be = '{8'hF0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    lit_d  = '{8'h01, 8'h03, 8'h03, 8'h03, 8'h06, 8'h06, 8'h06, 8'h0D};
    lit_w  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    tick();
    tick();
    check("rst_write", write_b, 0);
    check("rst_busy", busy_b, 0);
    check("rst_ready", ready_b, 1);
    check("rst_ready_w", ready_w, 1);
    check("rst_addr", addr_b, 0);
    check("rst_data", data_b, 0);
    check("rst_be", be_b, 0);
    check("rst_bc", bc_b, 0);
    rst_i = 1'b1;
    tick();

    // Single word, fixed pattern
    send_pkt(32'h100, 16'd1, 8'h11, 8'h3C, 8'h22, 8'hA5, 1'b0);
    check("single_lat_write", write_b, 0);
    tick();
    check("single_write", write_b, 1);
    check("single_busy", busy_b, 1);
    check("single_addr", addr_b, 32'h100);
    check("single_bc", bc_b, 1);
    check("single_be", be_b, 8'h3C);
    check("single_data", data_b, 64'hA5A5A5A5A5A5A5A5);
    drain("single");

    // LFSR burst with two 2-cycle stalls
    send_pkt(32'h2000, 16'd4, 8'hF0, 8'h55, 8'h0F, 8'h01, 1'b1);
    tick();
    for (int k = 0; k < 8; k++) begin
      check("lfsr_write", write_b, 1);
      check("lfsr_be", be_b, lit_be[k]);
      check("lfsr_byte", data_b[7:0], lit_d[k]);
      waitreq = lit_w[k];
      tick();
    end
    check("lfsr_end_write", write_b, 0);
    waitreq = 1'b0;
    drain("lfsr");

    // Back-to-back: no gap between bursts
    send_pkt(32'h1000, 16'd3, 8'h01, 8'h02, 8'h04, 8'h5A, 1'b0);
    check("b2b_ready_low", ready_b, 0);
    send_pkt(32'h3008, 16'd2, 8'hC0, 8'h18, 8'h03, 8'h77, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("b2b_write", write_b, 1);
      if (k == 2) begin
        check("b2b_b_addr", addr_b, 32'h3008);
        check("b2b_b_bc", bc_b, 2);
      end
      tick();
    end
    check("b2b_end_write", write_b, 0);
    drain("b2b");

    // Zero count: consumed, busy pulse only
    send_pkt(32'h400, 16'd0, 8'hFF, 8'hFF, 8'hFF, 8'h33, 1'b0);
    check("zero_ready_low", ready_b, 0);
    check("zero_busy0", busy_b, 0);
    tick();
    check("zero_ready_back", ready_b, 1);
    check("zero_busy_pulse", busy_b, 1);
    check("zero_write", write_b, 0);
    tick();
    check("zero_busy_end", busy_b, 0);
    check("zero_write2", write_b, 0);

    // Address type handling
    send_pkt(32'h11, 16'd1, 8'h00, 8'hFF, 8'h00, 8'h3C, 1'b0);
    tick();
    check("addr_word_11", addr_w, 32'h11);
    check("addr_byte_11", addr_b, 32'h10);
    drain("addr1");
    send_pkt(32'h13, 16'd2, 8'hFE, 8'h00, 8'h7F, 8'hC3, 1'b1);
    tick();
    check("addr_byte_13", addr_b, 32'h10);
    check("addr_word_13", addr_w, 32'h13);
    drain("addr2");

    // Reset during beat 2 of 8
    send_pkt(32'h5000, 16'd8, 8'hAA, 8'h00, 8'h55, 8'h9E, 1'b1);
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    check("mrst_write", write_b, 0);
    check("mrst_write_w", write_w, 0);
    check("mrst_busy", busy_b, 0);
    check("mrst_ready", ready_b, 1);
    check("mrst_addr", addr_b, 0);
    rst_i = 1'b1;
    tick();
    send_pkt(32'h6040, 16'd8, 8'h81, 8'h00, 8'h18, 8'h47, 1'b1);
    drain("after_rst");

    // Randomised traffic with random stalls
    rand_wait = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [15:0] n;
      if (i == 10)                         n = 16'd1024;
      else if ($urandom_range(0, 7) == 0)  n = 16'd0;
      else                                 n = 16'($urandom_range(1, 12));
      send_pkt($urandom(), n, 8'($urandom()), 8'($urandom()), 8'($urandom()),
               8'($urandom()), 1'($urandom()));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
    rand_wait = 1'b0;
    waitreq = 1'b0;
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
